// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the arbitrating multiplexer: mode encodings and
// the channel-index width helper.
package rr_arb_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Index width for n channels; never narrower than one bit.
  function automatic int cw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker: rotating search after ptr, or lowest
// index first when mode_i is set.
module rr_pick
  import rr_arb_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cw_of(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [CW-1:0] ptr_i,
  input  logic          mode_i,
  output logic          gnt_any_o,
  output logic [CW-1:0] gnt_idx_o
);

  // Both loops walk the search order backwards so the candidate found
  // first in search order is the last one written, avoiding a break.
  always_comb begin
    gnt_any_o = 1'b0;
    gnt_idx_o = '0;
    if (mode_i) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          gnt_any_o = 1'b1;
          gnt_idx_o = CW'(i);
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        if (req_i[(int'(ptr_i) + k) % N]) begin
          gnt_any_o = 1'b1;
          gnt_idx_o = CW'((int'(ptr_i) + k) % N);
        end
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with a single-slot registered output and
// valid/ready handshakes; round-robin or fixed-priority selection.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int MODE = MODE_RR,
  localparam int CW  = cw_of(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [CW-1:0]   out_ch,
  input  logic            out_ready
);

  localparam logic FIXED_SEL = (MODE == MODE_FIXED);

  logic [CW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;

  logic          gnt_any;
  logic [CW-1:0] gnt_idx;
  logic          load_ok;
  logic          accept;
  logic [W-1:0]  sel_data;

  rr_pick #(
    .N  (N),
    .CW (CW)
  ) u_pick (
    .req_i     (in_valid),
    .ptr_i     (ptr_q),
    .mode_i    (FIXED_SEL),
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

  // The slot may refill when empty or when its beat leaves this cycle.
  assign load_ok = !out_valid_q || out_ready;
  assign accept  = load_ok && gnt_any;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == CW'(i)) begin
        in_ready[i] = accept;
        sel_data    = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = gnt_idx;
      if (!FIXED_SEL) ptr_d = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= CW'(N - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed and random checks of rr_arb_mux, round-robin and fixed-priority
// instances side by side against a behavioural model.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk;
  logic             reset;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic             out_ready;

  logic [N-1:0]     in_ready_w  [2];
  logic             out_valid_w [2];
  logic [W-1:0]     out_data_w  [2];
  logic [1:0]       out_ch_w    [2];

  int checks = 0;
  int errors = 0;

  // model state, index 0 = round-robin, 1 = fixed priority
  bit          m_valid [2];
  logic [31:0] m_data  [2];
  int          m_ch    [2];
  int          m_last  [2];

  rr_arb_mux #(.N(N), .W(W), .MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]),
    .out_data(out_data_w[0]), .out_ch(out_ch_w[0]), .out_ready(out_ready)
  );

  rr_arb_mux #(.N(N), .W(W), .MODE(1)) dut_fx (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]),
    .out_data(out_data_w[1]), .out_ch(out_ch_w[1]), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int inst, input logic [N-1:0] v);
    if (inst == 1) begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
    end
    for (int k = 1; k <= N; k++) if (v[(m_last[inst] + k) % N]) return (m_last[inst] + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int inst);
    int g;
    g = pick(inst, in_valid);
    if ((!m_valid[inst] || out_ready) && g >= 0) return N'(1 << g);
    return '0;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_valid[j] = 1'b0;
      m_data[j]  = '0;
      m_ch[j]    = 0;
      m_last[j]  = N - 1;
    end
  endtask

  task automatic check_outs();
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("out_valid%0d", j), 32'(out_valid_w[j]), 32'(m_valid[j]));
      chk($sformatf("out_data%0d", j), out_data_w[j], m_data[j]);
      chk($sformatf("out_ch%0d", j), 32'(out_ch_w[j]), 32'(m_ch[j]));
    end
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic cycle();
    int  g   [2];
    bit  acc [2];
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("in_ready%0d", j), 32'(in_ready_w[j]), 32'(exp_ready(j)));
      g[j]   = pick(j, in_valid);
      acc[j] = (!m_valid[j] || out_ready) && g[j] >= 0;
    end
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      if (acc[j]) begin
        m_valid[j] = 1'b1;
        m_data[j]  = in_data[g[j]*W +: W];
        m_ch[j]    = g[j];
        if (j == 0) m_last[j] = g[j];
      end else if (out_ready) begin
        m_valid[j] = 1'b0;
      end
    end
    #1;
    check_outs();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("rst_out_data", out_data_w[0], 32'd0);
    chk("rst_out_ch", 32'(out_ch_w[0]), 32'd0);
    check_outs();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_counting_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h1000 + i;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    #1 reset = 1'b0;

    // reset mid-beat
    in_valid = 4'b0100;
    in_data[2*W +: W] = 32'hAAAA0002;
    cycle();
    chk("mid_beat_ch", 32'(out_ch_w[0]), 32'd2);
    chk("mid_beat_data", out_data_w[0], 32'hAAAA0002);
    pulse_reset();
    in_valid = 4'b1111;
    set_counting_data();
    out_ready = 1'b1;
    cycle();
    chk("post_reset_first", 32'(out_ch_w[0]), 32'd0);

    // round-robin rotation from a clean reset
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_rot_ch", 32'(out_ch_w[0]), 32'(k % N));
      chk("rr_rot_data", out_data_w[0], 32'h1000 + 32'(k % N));
      chk("rr_rot_valid", 32'(out_valid_w[0]), 32'd1);
    end

    // wrap and skip
    in_valid = 4'b1000;
    cycle();
    chk("wrap_ch3", 32'(out_ch_w[0]), 32'd3);
    in_valid = 4'b0100;
    #1 chk("wrap_ready", 32'(in_ready_w[0]), 32'b0100);
    cycle();
    chk("wrap_ch2", 32'(out_ch_w[0]), 32'd2);
    in_valid = 4'b1001;
    cycle();
    chk("wrap_3_before_0", 32'(out_ch_w[0]), 32'd3);

    // backpressure
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_ready", 32'(in_ready_w[0]), 32'd0);
      chk("bp_ch", 32'(out_ch_w[0]), 32'd3);
      chk("bp_data", out_data_w[0], 32'h1003);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready_w[0]), 32'b0001);
    cycle();
    chk("bp_release_ch", 32'(out_ch_w[0]), 32'd0);
    chk("bp_release_valid", 32'(out_valid_w[0]), 32'd1);

    // fixed priority
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("fx_ch1", 32'(out_ch_w[1]), 32'd1);
      chk("fx_ready", 32'(in_ready_w[1]), 32'b0010);
    end
    in_valid = 4'b1000;
    cycle();
    chk("fx_ch3", 32'(out_ch_w[1]), 32'd3);

    // idle drain
    pulse_reset();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    cycle();
    in_valid = 4'b0000;
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    chk("idle_valid", 32'(out_valid_w[0]), 32'd0);
    chk("idle_data", out_data_w[0], 32'h1001);
    chk("idle_ch", 32'(out_ch_w[0]), 32'd1);
    cycle();
    chk("idle_ready", 32'(in_ready_w[0]), 32'd0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      in_valid  = N'($urandom);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) pulse_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
